// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game sequencer and its neighbours: key/collision
// inputs coming in, status/flash/restart/turn information going out.
// The controller takes the master view; the surrounding logic uses slave.
interface game_flow_ctrl_if #(
    parameter int NUM_KEYS = 4,
    parameter int TEAM_W   = 1
);
    logic [NUM_KEYS-1:0] key_press;
    logic                pause_key;
    logic                hit_wall;
    logic                hit_body;
    logic                hit_min_length;
    logic [2:0]          game_status;
    logic                die_flash;
    logic                restart;
    logic [TEAM_W-1:0]   team_idx;
    logic                round_done;
    logic                game_over;

    modport master (
        input  key_press, pause_key, hit_wall, hit_body, hit_min_length,
        output game_status, die_flash, restart, team_idx, round_done, game_over
    );

    modport slave (
        output key_press, pause_key, hit_wall, hit_body, hit_min_length,
        input  game_status, die_flash, restart, team_idx, round_done, game_over
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer for the snake game:
// START -> PLAY -> DIE -> RESTART, with an optional PAUSE and a multi-team
// turn counter ending in OVER. All outputs are registered.
// Optional feature macro: GAME_PAUSE_EN (enables PAUSE and pause_key).
//
// state   | code | meaning
// --------+------+-----------------------------------------------------
// RESTART |  0   | restart held high while the snake engine reinitialises
// START   |  1   | waiting for any key to begin the turn
// PLAY    |  2   | turn in progress, waiting for a collision
// DIE     |  3   | death animation, die_flash blinks, fixed duration
// PAUSE   |  4   | play frozen until the next pause_key
// OVER    |  5   | all teams have played, waiting for a key to start over
module game_flow_ctrl #(
    parameter int NUM_KEYS       = 4,
    parameter int NUM_TEAMS      = 2,
    parameter int RESTART_CYCLES = 6,
    parameter int FLASH_PERIOD   = 25_000_000,
    parameter int FLASH_TOGGLES  = 6,
    parameter int DIE_CYCLES     = 200_000_001,
    parameter int CNT_W          = 32
) (
    input  logic          clk,
    input  logic          rst,
    game_flow_ctrl_if.master bus
);
    localparam int TEAM_W = (NUM_TEAMS > 1) ? $clog2(NUM_TEAMS) : 1;
    localparam int TGL_W  = (FLASH_TOGGLES > 0) ? $clog2(FLASH_TOGGLES + 1) : 1;

    localparam logic [2:0] S_RESTART = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_PLAY    = 3'd2;
    localparam logic [2:0] S_DIE     = 3'd3;
`ifdef GAME_PAUSE_EN
    localparam logic [2:0] S_PAUSE   = 3'd4;
`endif
    localparam logic [2:0] S_OVER    = 3'd5;

    localparam logic [CNT_W-1:0]  DIE_LAST     = CNT_W'(DIE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RESTART_LAST = CNT_W'(RESTART_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FLASH_LOAD   = CNT_W'(FLASH_PERIOD);
    localparam logic [CNT_W-1:0]  FLASH_RELOAD = CNT_W'(FLASH_PERIOD - 1);
    localparam logic [TGL_W-1:0]  TGL_LOAD     = TGL_W'(FLASH_TOGGLES);
    localparam logic [TEAM_W-1:0] TEAM_LAST    = TEAM_W'(NUM_TEAMS - 1);

    logic [2:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    // flash_tmr hits zero exactly when cnt reaches the next multiple of FLASH_PERIOD
    logic [CNT_W-1:0]  flash_tmr, flash_tmr_n;
    logic [TGL_W-1:0]  flash_left, flash_left_n;
    logic              die_flash_q, die_flash_n;
    logic              restart_q;
    logic [TEAM_W-1:0] team_q, team_n;
    logic              round_done_q, round_done_n;
    logic              game_over_q;
    logic              hit;
    logic              any_key;

    assign hit     = bus.hit_wall | bus.hit_body | bus.hit_min_length;
    assign any_key = |bus.key_press;

`ifndef GAME_PAUSE_EN
    // pause_key is kept on the interface but has no effect in this build
    logic unused_pause;
    assign unused_pause = bus.pause_key;
`endif

    assign bus.game_status = state;
    assign bus.die_flash   = die_flash_q;
    assign bus.restart     = restart_q;
    assign bus.team_idx    = team_q;
    assign bus.round_done  = round_done_q;
    assign bus.game_over   = game_over_q;

    // Next-state, counter and flash/turn bookkeeping
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        flash_tmr_n  = flash_tmr;
        flash_left_n = flash_left;
        die_flash_n  = die_flash_q;
        team_n       = team_q;
        round_done_n = 1'b0;
        case (state)
            S_START: begin
                if (any_key) state_n = S_PLAY;
            end
            S_PLAY: begin
                if (hit) begin
                    state_n      = S_DIE;
                    cnt_n        = '0;
                    flash_tmr_n  = FLASH_LOAD;
                    flash_left_n = TGL_LOAD;
                    die_flash_n  = 1'b1;
                end
`ifdef GAME_PAUSE_EN
                else if (bus.pause_key) begin
                    state_n = S_PAUSE;
                end
`endif
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (bus.pause_key) state_n = S_PLAY;
            end
`endif
            S_DIE: begin
                if (cnt == DIE_LAST) begin
                    cnt_n        = '0;
                    die_flash_n  = 1'b1;
                    round_done_n = 1'b1;
                    if (team_q == TEAM_LAST) begin
                        state_n = S_OVER;
                    end else begin
                        team_n  = team_q + TEAM_W'(1);
                        state_n = S_RESTART;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (flash_tmr == '0) begin
                        if (flash_left != '0) begin
                            die_flash_n  = ~die_flash_q;
                            flash_left_n = flash_left - TGL_W'(1);
                        end
                        flash_tmr_n = FLASH_RELOAD;
                    end else begin
                        flash_tmr_n = flash_tmr - CNT_W'(1);
                    end
                end
            end
            S_RESTART: begin
                if (cnt == RESTART_LAST) begin
                    state_n = S_START;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_OVER: begin
                if (any_key) begin
                    team_n  = '0;
                    cnt_n   = '0;
                    state_n = S_RESTART;
                end
            end
            default: begin
                state_n     = S_START;
                cnt_n       = '0;
                die_flash_n = 1'b1;
            end
        endcase
    end

    // State and output registers; restart/game_over follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_START;
            cnt          <= '0;
            flash_tmr    <= '0;
            flash_left   <= '0;
            die_flash_q  <= 1'b1;
            restart_q    <= 1'b0;
            team_q       <= '0;
            round_done_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            flash_tmr    <= flash_tmr_n;
            flash_left   <= flash_left_n;
            die_flash_q  <= die_flash_n;
            restart_q    <= (state_n == S_RESTART);
            team_q       <= team_n;
            round_done_q <= round_done_n;
            game_over_q  <= (state_n == S_OVER);
        end
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios followed by a
// randomized run compared against a duration-based reference model.
module tb_game_flow_ctrl;
    localparam int NK  = 4;
    localparam int NT  = 2;
    localparam int RC  = 6;
    localparam int FP  = 4;
    localparam int TG  = 6;
    localparam int DIE = 32;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    // reference model: current state code, cycle it was entered, team, pulse
    int   cyc;
    int   m_st;
    int   m_enter;
    int   m_team;
    logic m_rd;

    game_flow_ctrl_if #(.NUM_KEYS(NK), .TEAM_W(1)) bus ();

    game_flow_ctrl #(
        .NUM_KEYS(NK), .NUM_TEAMS(NT), .RESTART_CYCLES(RC),
        .FLASH_PERIOD(FP), .FLASH_TOGGLES(TG), .DIE_CYCLES(DIE), .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // die_flash after e cycles in DIE: one inversion per full flash period
    // completed strictly before e, capped at the toggle count
    function automatic logic flash_ref(input int e);
        int n;
        if (e <= 0) return 1'b1;
        n = (e - 1) / FP;
        if (n > TG) n = TG;
        return (n % 2) == 0;
    endfunction

    task automatic model_step(input logic [NK-1:0] k, input logic p, input logic h, input logic r);
        cyc++;
        m_rd = 1'b0;
        if (r) begin
            m_st = 1; m_team = 0; m_enter = cyc;
            return;
        end
        case (m_st)
            1: if (k != 0) begin m_st = 2; m_enter = cyc; end
            2: begin
                if (h) begin m_st = 3; m_enter = cyc; end
                else if (PAUSE_EN && p) begin m_st = 4; m_enter = cyc; end
            end
            4: if (p) begin m_st = 2; m_enter = cyc; end
            3: if (cyc - m_enter == DIE) begin
                m_rd = 1'b1;
                if (m_team == NT - 1) m_st = 5;
                else begin m_team++; m_st = 0; end
                m_enter = cyc;
            end
            0: if (cyc - m_enter == RC) begin m_st = 1; m_enter = cyc; end
            5: if (k != 0) begin m_team = 0; m_st = 0; m_enter = cyc; end
            default: begin m_st = 1; m_enter = cyc; end
        endcase
    endtask

    // one clock: apply inputs, advance model, leave outputs ready to sample
    task automatic cycle(input logic [NK-1:0] k, input logic p, input logic hw,
                         input logic hb, input logic hm);
        bus.key_press = k; bus.pause_key = p;
        bus.hit_wall = hw; bus.hit_body = hb; bus.hit_min_length = hm;
        @(posedge clk);
        model_step(k, p, hw | hb | hm, rst);
        #1;
        bus.key_press = '0; bus.pause_key = 1'b0;
        bus.hit_wall = 1'b0; bus.hit_body = 1'b0; bus.hit_min_length = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cycle(0, 0, 0, 0, 0);
        cycle(4'hF, 1, 1, 1, 1);
        rst = 1'b0;
        cycle(0, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd1) begin n_fail++; $display("FAIL reset_status got %0d exp 1", bus.game_status); end
        n_tests++; if (bus.die_flash !== 1'b1) begin n_fail++; $display("FAIL reset_flash got %b exp 1", bus.die_flash); end
        n_tests++; if (bus.restart !== 1'b0) begin n_fail++; $display("FAIL reset_restart got %b exp 0", bus.restart); end
        n_tests++; if (bus.team_idx !== 1'b0) begin n_fail++; $display("FAIL reset_team got %0d exp 0", bus.team_idx); end
        n_tests++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL reset_over got %b exp 0", bus.game_over); end
        n_tests++; if (bus.round_done !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %b exp 0", bus.round_done); end
        cycle(4'b0100, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd2) begin n_fail++; $display("FAIL start_play got %0d exp 2", bus.game_status); end
    endtask

    task automatic test_die;
        cycle(0, 0, 1, 0, 0);
        for (int e = 0; e < DIE; e++) begin
            n_tests++; if (bus.game_status !== 3'd3) begin n_fail++; $display("FAIL die_status e=%0d got %0d exp 3", e, bus.game_status); end
            n_tests++; if (bus.die_flash !== flash_ref(e)) begin n_fail++; $display("FAIL die_flash e=%0d got %b exp %b", e, bus.die_flash, flash_ref(e)); end
            n_tests++; if (bus.round_done !== 1'b0) begin n_fail++; $display("FAIL die_rd e=%0d got %b exp 0", e, bus.round_done); end
            cycle(0, 0, 0, 0, 0);
        end
        n_tests++; if (bus.game_status !== 3'd0) begin n_fail++; $display("FAIL die_exit got %0d exp 0", bus.game_status); end
        n_tests++; if (bus.round_done !== 1'b1) begin n_fail++; $display("FAIL die_rd_pulse got %b exp 1", bus.round_done); end
        n_tests++; if (bus.team_idx !== 1'b1) begin n_fail++; $display("FAIL die_team got %0d exp 1", bus.team_idx); end
        n_tests++; if (bus.die_flash !== 1'b1) begin n_fail++; $display("FAIL die_flash_exit got %b exp 1", bus.die_flash); end
        n_tests++; if (bus.restart !== 1'b1) begin n_fail++; $display("FAIL rst_pulse i=0 got %b exp 1", bus.restart); end
        for (int i = 1; i < RC; i++) begin
            cycle(4'hF, 1, 1, 1, 1);
            n_tests++; if (bus.restart !== 1'b1 || bus.game_status !== 3'd0) begin n_fail++; $display("FAIL rst_pulse i=%0d got %b/%0d exp 1/0", i, bus.restart, bus.game_status); end
            n_tests++; if (bus.round_done !== 1'b0) begin n_fail++; $display("FAIL rd_once i=%0d got %b exp 0", i, bus.round_done); end
        end
        cycle(0, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd1 || bus.restart !== 1'b0) begin n_fail++; $display("FAIL restart_end got %0d/%b exp 1/0", bus.game_status, bus.restart); end
        n_tests++; if (bus.team_idx !== 1'b1) begin n_fail++; $display("FAIL start_team got %0d exp 1", bus.team_idx); end
    endtask

    task automatic test_pause;
        cycle(4'b1000, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd2) begin n_fail++; $display("FAIL pause_play got %0d exp 2", bus.game_status); end
        cycle(0, 1, 0, 0, 0);
`ifdef GAME_PAUSE_EN
        n_tests++; if (bus.game_status !== 3'd4) begin n_fail++; $display("FAIL pause_enter got %0d exp 4", bus.game_status); end
        cycle(0, 0, 0, 1, 0);
        n_tests++; if (bus.game_status !== 3'd4) begin n_fail++; $display("FAIL pause_hit got %0d exp 4", bus.game_status); end
        cycle(4'b0010, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd4) begin n_fail++; $display("FAIL pause_key got %0d exp 4", bus.game_status); end
        cycle(0, 1, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd2) begin n_fail++; $display("FAIL pause_exit got %0d exp 2", bus.game_status); end
`else
        n_tests++; if (bus.game_status !== 3'd2) begin n_fail++; $display("FAIL pause_ignored got %0d exp 2", bus.game_status); end
`endif
        cycle(0, 1, 0, 0, 1);
        n_tests++; if (bus.game_status !== 3'd3) begin n_fail++; $display("FAIL hit_beats_pause got %0d exp 3", bus.game_status); end
    endtask

    task automatic test_reset_mid_die;
        repeat (17) cycle(0, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd3 || bus.team_idx !== 1'b1) begin n_fail++; $display("FAIL mid_die_pre got %0d/%0d exp 3/1", bus.game_status, bus.team_idx); end
        rst = 1'b1;
        cycle(0, 0, 0, 0, 0);
        rst = 1'b0;
        n_tests++; if (bus.game_status !== 3'd1) begin n_fail++; $display("FAIL mid_die_status got %0d exp 1", bus.game_status); end
        n_tests++; if (bus.die_flash !== 1'b1 || bus.team_idx !== 1'b0) begin n_fail++; $display("FAIL mid_die_flash_team got %b/%0d exp 1/0", bus.die_flash, bus.team_idx); end
        // a fresh death must again last the full duration (counter discarded)
        cycle(4'b0001, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (DIE - 1) cycle(0, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd3) begin n_fail++; $display("FAIL die_len_pre got %0d exp 3", bus.game_status); end
        cycle(0, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd0) begin n_fail++; $display("FAIL die_len_post got %0d exp 0", bus.game_status); end
        repeat (RC) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic test_over;
        n_tests++; if (bus.game_status !== 3'd1 || bus.team_idx !== 1'b1) begin n_fail++; $display("FAIL over_pre got %0d/%0d exp 1/1", bus.game_status, bus.team_idx); end
        cycle(4'b0001, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (DIE) cycle(0, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd5 || bus.game_over !== 1'b1) begin n_fail++; $display("FAIL over_enter got %0d/%b exp 5/1", bus.game_status, bus.game_over); end
        n_tests++; if (bus.round_done !== 1'b1 || bus.restart !== 1'b0) begin n_fail++; $display("FAIL over_rd got %b/%b exp 1/0", bus.round_done, bus.restart); end
        cycle(0, 1, 1, 1, 1);
        n_tests++; if (bus.game_status !== 3'd5 || bus.round_done !== 1'b0) begin n_fail++; $display("FAIL over_hold got %0d/%b exp 5/0", bus.game_status, bus.round_done); end
        cycle(4'b0001, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd0 || bus.restart !== 1'b1) begin n_fail++; $display("FAIL over_exit got %0d/%b exp 0/1", bus.game_status, bus.restart); end
        n_tests++; if (bus.team_idx !== 1'b0 || bus.game_over !== 1'b0) begin n_fail++; $display("FAIL over_clear got %0d/%b exp 0/0", bus.team_idx, bus.game_over); end
        repeat (RC) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic test_illegal;
        cycle(4'b0100, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd2) begin n_fail++; $display("FAIL illegal_pre got %0d exp 2", bus.game_status); end
        @(negedge clk);
        force dut.state = 3'd7;
        #1;
        release dut.state;
        m_st = 7;
        cycle(0, 0, 0, 0, 0);
        n_tests++; if (bus.game_status !== 3'd1) begin n_fail++; $display("FAIL illegal_recover got %0d exp 1", bus.game_status); end
    endtask

    task automatic test_random;
        logic [NK-1:0] k;
        logic          p, hw, hb, hm;
        logic [7:0]    got, exp;
        rst = 1'b1;
        cycle(0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            k  = ($urandom_range(0, 5) == 0) ? NK'($urandom_range(1, 15)) : '0;
            p  = ($urandom_range(0, 6) == 0);
            hw = ($urandom_range(0, 15) == 0);
            hb = ($urandom_range(0, 15) == 0);
            hm = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 499) == 0);
            cycle(k, p, hw, hb, hm);
            got = {bus.game_status, bus.die_flash, bus.restart, bus.team_idx, bus.round_done, bus.game_over};
            exp = {3'(m_st), (m_st == 3) ? flash_ref(cyc - m_enter) : 1'b1, m_st == 0,
                   1'(m_team), m_rd, m_st == 5};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random i=%0d {status,flash,restart,team,rd,over} got %b exp %b", i, got, exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        cyc = 0; m_st = 1; m_enter = 0; m_team = 0; m_rd = 1'b0;
        rst = 1'b1;
        bus.key_press = '0; bus.pause_key = 1'b0;
        bus.hit_wall = 1'b0; bus.hit_body = 1'b0; bus.hit_min_length = 1'b0;
        test_reset;
        test_die;
        test_pause;
        test_reset_mid_die;
        test_over;
        test_illegal;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
